niosii_buttons: RTL and testbench



---
 rtl/niosii_buttons.sv | 176 +++++++++++++++++
 tb/tb_niosii_buttons.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/niosii_buttons.sv
// niosii_buttons: Avalon-MM input PIO for push-buttons and switches.
// Inputs are double-flop synchronised, debounced per bit, and exposed on
// the bus. Selected edges of the debounced value are latched per bit in an
// edgecapture register, and a registered level IRQ is raised when any
// captured bit is also enabled in irqmask.
//
// Register map (word address):
//   0 data        : debounced input value (read-only)
//   1 irqmask     : per-bit interrupt enable (read/write)
//   2 reserved    : reads 0, writes ignored
//   3 edgecapture : captured edges, write-1-to-clear per bit
//
// Bus handshake: the slave has zero wait states. A write is taken on any
// clk edge where chipselect=1 and write_n=0. readdata is a combinational
// function of address and the registers (read latency 0), so reads carry
// no side effects and chipselect is not needed to qualify them.
module niosii_buttons #(
    parameter int               WIDTH           = 4,
    parameter logic [WIDTH-1:0] RESET_VALUE     = '0,
    parameter int               DEBOUNCE_CYCLES = 50000,
    parameter int               EDGE_TYPE       = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_MASK = 2'd1;
    localparam logic [1:0] ADDR_EDGE = 2'd3;

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [WIDTH-1:0] w_stable;
    logic [WIDTH-1:0] r_prev;
    logic [WIDTH-1:0] r_edgecapture;
    logic [WIDTH-1:0] r_irqmask;
    logic             r_irq;

    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_fall;
    logic [WIDTH-1:0] w_edge;
    logic [WIDTH-1:0] w_clear;
    logic             w_write;
    logic             w_wr_mask;
    logic             w_wr_edge;
    logic             w_unused_ok;

    // Upper writedata bits are never stored when WIDTH < 32.
    assign w_unused_ok = &{1'b0, writedata};

    // Two-flop synchroniser for the asynchronous external inputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= RESET_VALUE;
            r_sync2 <= RESET_VALUE;
        end else begin
            r_sync1 <= in_port;
            r_sync2 <= r_sync1;
        end
    end

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            logic [WIDTH-1:0] r_stable;

            // No debounce: the stable value simply follows the synchroniser.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_stable <= RESET_VALUE;
                end else begin
                    r_stable <= r_sync2;
                end
            end

            assign w_stable = r_stable;
        end else begin : g_debounce
            localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
            localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

            for (genvar i = 0; i < WIDTH; i++) begin : g_bit
                logic [CW-1:0] r_count;
                logic          r_stable_bit;

                // Accept a new level only after it has persisted for
                // DEBOUNCE_CYCLES consecutive cycles; any return to the
                // stable level restarts the count, so the counter is
                // bounded by LAST and never wraps.
                always_ff @(posedge clk or negedge reset_n) begin
                    if (!reset_n) begin
                        r_count      <= '0;
                        r_stable_bit <= RESET_VALUE[i];
                    end else if (r_sync2[i] == r_stable_bit) begin
                        r_count <= '0;
                    end else if (r_count == LAST) begin
                        r_stable_bit <= r_sync2[i];
                        r_count      <= '0;
                    end else begin
                        r_count <= r_count + 1'b1;
                    end
                end

                assign w_stable[i] = r_stable_bit;
            end
        end
    endgenerate

    // Previous stable value for edge detection; resetting it to the same
    // value as stable guarantees no spurious edge out of reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_prev <= RESET_VALUE;
        end else begin
            r_prev <= w_stable;
        end
    end

    assign w_rise = w_stable & ~r_prev;
    assign w_fall = ~w_stable & r_prev;
    assign w_edge = (EDGE_TYPE == 0) ? w_rise :
                    (EDGE_TYPE == 1) ? w_fall :
                                       (w_rise | w_fall);

    assign w_write   = chipselect & ~write_n;
    assign w_wr_mask = w_write && (address == ADDR_MASK);
    assign w_wr_edge = w_write && (address == ADDR_EDGE);
    assign w_clear   = w_wr_edge ? writedata[WIDTH-1:0] : '0;

    // Edge capture: a new edge in the same cycle as a clear wins, so the
    // OR with w_edge is applied after the clear mask.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_edgecapture <= '0;
        end else begin
            r_edgecapture <= (r_edgecapture & ~w_clear) | w_edge;
        end
    end

    // Interrupt mask register; it does not gate capture, only the IRQ.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_irqmask <= '0;
        end else if (w_wr_mask) begin
            r_irqmask <= writedata[WIDTH-1:0];
        end
    end

    // Registered level interrupt from pending, enabled capture bits.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= |(r_edgecapture & r_irqmask);
        end
    end

    assign irq = r_irq;

    // Combinational read mux; bits above WIDTH and the reserved word read 0.
    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA: readdata[WIDTH-1:0] = w_stable;
            ADDR_MASK: readdata[WIDTH-1:0] = r_irqmask;
            ADDR_EDGE: readdata[WIDTH-1:0] = r_edgecapture;
            default:   readdata = '0;
        endcase
    end

endmodule

// File: tb/tb_niosii_buttons.sv
// Bench for niosii_buttons: three instances (EDGE_TYPE 0, 1, 2) share the
// clock, reset and bus; each has its own in_port. Expected values are
// pushed to exp_q when stimulus is applied and popped at the check.
module tb_niosii_buttons;

    localparam int W = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [W-1:0] in_p [3];
    logic [31:0] rd [3];
    logic        irq_v [3];

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_v;

    always #5 clk = ~clk;

    genvar g;
    generate
        for (g = 0; g < 3; g++) begin : g_dut
            niosii_buttons #(
                .WIDTH(W),
                .RESET_VALUE(4'b0000),
                .DEBOUNCE_CYCLES(4),
                .EDGE_TYPE(g)
            ) u_dut (
                .clk(clk),
                .reset_n(reset_n),
                .address(address),
                .chipselect(chipselect),
                .write_n(write_n),
                .writedata(writedata),
                .in_port(in_p[g]),
                .readdata(rd[g]),
                .irq(irq_v[g])
            );
        end
    endgenerate

    // Wait n rising edges, then settle on the following falling edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    // Single-cycle write, committed on the next rising edge.
    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        step(1);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    // Present a read address; readdata is valid 1 time unit later.
    task automatic rd_at(input logic [1:0] a);
        address = a;
        #1;
    endtask

    task automatic test_reset;
        reset_n = 1'b0; address = 2'd0; chipselect = 1'b0; write_n = 1'b1;
        writedata = '0;
        for (int k = 0; k < 3; k++) in_p[k] = '0;
        #23;
        reset_n = 1'b1;
        step(1);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        rd_at(2'd0); exp_v = exp_q.pop_front(); checks++;
        if (rd[0] !== exp_v) begin errors++; $display("FAIL reset_data got %h want %h", rd[0], exp_v); end
        rd_at(2'd1); exp_v = exp_q.pop_front(); checks++;
        if (rd[0] !== exp_v) begin errors++; $display("FAIL reset_mask got %h want %h", rd[0], exp_v); end
        rd_at(2'd3); exp_v = exp_q.pop_front(); checks++;
        if (rd[0] !== exp_v) begin errors++; $display("FAIL reset_edge got %h want %h", rd[0], exp_v); end
        exp_v = exp_q.pop_front(); checks++;
        if ({31'b0, irq_v[0]} !== exp_v) begin errors++; $display("FAIL reset_irq got %0b want %0d", irq_v[0], exp_v); end
    endtask

    task automatic test_glitch_and_debounce;
        step(1);
        // 3-cycle glitch must be rejected.
        in_p[0] = 4'h1;
        step(3);
        in_p[0] = 4'h0;
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        step(6);
        rd_at(2'd0); exp_v = exp_q.pop_front(); checks++;
        if (rd[0] !== exp_v) begin errors++; $display("FAIL glitch_data got %h want %h", rd[0], exp_v); end
        rd_at(2'd3); exp_v = exp_q.pop_front(); checks++;
        if (rd[0] !== exp_v) begin errors++; $display("FAIL glitch_edge got %h want %h", rd[0], exp_v); end
        // Held level: accepted exactly 2+4 clk later, captured 1 clk after.
        in_p[0] = 4'h1;
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h1);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h1);
        step(5);
        rd_at(2'd0); exp_v = exp_q.pop_front(); checks++;
        if (rd[0] !== exp_v) begin errors++; $display("FAIL debounce_early got %h want %h", rd[0], exp_v); end
        step(1);
        rd_at(2'd0); exp_v = exp_q.pop_front(); checks++;
        if (rd[0] !== exp_v) begin errors++; $display("FAIL debounce_accept got %h want %h", rd[0], exp_v); end
        rd_at(2'd3); exp_v = exp_q.pop_front(); checks++;
        if (rd[0] !== exp_v) begin errors++; $display("FAIL edge_not_yet got %h want %h", rd[0], exp_v); end
        step(1);
        rd_at(2'd3); exp_v = exp_q.pop_front(); checks++;
        if (rd[0] !== exp_v) begin errors++; $display("FAIL edge_capture got %h want %h", rd[0], exp_v); end
    endtask

    task automatic test_irq;
        bus_write(2'd1, 32'h1);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h1);
        exp_q.push_back(32'h1);
        exp_v = exp_q.pop_front(); checks++;
        if ({31'b0, irq_v[0]} !== exp_v) begin errors++; $display("FAIL irq_mask_lat got %0b want %0d", irq_v[0], exp_v); end
        step(1);
        exp_v = exp_q.pop_front(); checks++;
        if ({31'b0, irq_v[0]} !== exp_v) begin errors++; $display("FAIL irq_assert got %0b want %0d", irq_v[0], exp_v); end
        rd_at(2'd1); exp_v = exp_q.pop_front(); checks++;
        if (rd[0] !== exp_v) begin errors++; $display("FAIL mask_read got %h want %h", rd[0], exp_v); end
        // Writing zeros to edgecapture changes nothing.
        bus_write(2'd3, 32'h0);
        exp_q.push_back(32'h1);
        exp_q.push_back(32'h1);
        rd_at(2'd3); exp_v = exp_q.pop_front(); checks++;
        if (rd[0] !== exp_v) begin errors++; $display("FAIL clear0_edge got %h want %h", rd[0], exp_v); end
        exp_v = exp_q.pop_front(); checks++;
        if ({31'b0, irq_v[0]} !== exp_v) begin errors++; $display("FAIL clear0_irq got %0b want %0d", irq_v[0], exp_v); end
        // Write-1-to-clear; irq drops one clk later.
        bus_write(2'd3, 32'h1);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h1);
        exp_q.push_back(32'h0);
        rd_at(2'd3); exp_v = exp_q.pop_front(); checks++;
        if (rd[0] !== exp_v) begin errors++; $display("FAIL clear1_edge got %h want %h", rd[0], exp_v); end
        exp_v = exp_q.pop_front(); checks++;
        if ({31'b0, irq_v[0]} !== exp_v) begin errors++; $display("FAIL clear1_irq_lat got %0b want %0d", irq_v[0], exp_v); end
        step(1);
        exp_v = exp_q.pop_front(); checks++;
        if ({31'b0, irq_v[0]} !== exp_v) begin errors++; $display("FAIL clear1_irq got %0b want %0d", irq_v[0], exp_v); end
    endtask

    task automatic test_edge_types;
        // Rising 0->F on all instances (dut0 already has bit 0 high).
        for (int k = 0; k < 3; k++) in_p[k] = 4'hF;
        exp_q.push_back(32'hE);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'hF);
        step(8);
        rd_at(2'd3);
        for (int k = 0; k < 3; k++) begin
            exp_v = exp_q.pop_front(); checks++;
            if (rd[k] !== exp_v) begin errors++; $display("FAIL rise_edge_type%0d got %h want %h", k, rd[k], exp_v); end
        end
        bus_write(2'd3, 32'hF);
        // Falling F->0.
        for (int k = 0; k < 3; k++) in_p[k] = 4'h0;
        exp_q.push_back(32'h0);
        exp_q.push_back(32'hF);
        exp_q.push_back(32'hF);
        step(8);
        rd_at(2'd3);
        for (int k = 0; k < 3; k++) begin
            exp_v = exp_q.pop_front(); checks++;
            if (rd[k] !== exp_v) begin errors++; $display("FAIL fall_edge_type%0d got %h want %h", k, rd[k], exp_v); end
        end
        bus_write(2'd3, 32'hF);
    endtask

    task automatic test_edge_vs_clear;
        bus_write(2'd1, 32'h6);
        in_p[0] = 4'h2;
        exp_q.push_back(32'h2);
        exp_q.push_back(32'h1);
        step(8);
        rd_at(2'd3); exp_v = exp_q.pop_front(); checks++;
        if (rd[0] !== exp_v) begin errors++; $display("FAIL pend_bit1 got %h want %h", rd[0], exp_v); end
        exp_v = exp_q.pop_front(); checks++;
        if ({31'b0, irq_v[0]} !== exp_v) begin errors++; $display("FAIL pend_irq got %0b want %0d", irq_v[0], exp_v); end
        // Bit-2 edge is live after 6 rising edges; the clear commits on the 7th.
        in_p[0] = 4'h6;
        step(6);
        bus_write(2'd3, 32'h6);
        exp_q.push_back(32'h4);
        exp_q.push_back(32'h1);
        exp_q.push_back(32'h1);
        rd_at(2'd3); exp_v = exp_q.pop_front(); checks++;
        if (rd[0] !== exp_v) begin errors++; $display("FAIL edge_wins got %h want %h", rd[0], exp_v); end
        exp_v = exp_q.pop_front(); checks++;
        if ({31'b0, irq_v[0]} !== exp_v) begin errors++; $display("FAIL edge_wins_irq0 got %0b want %0d", irq_v[0], exp_v); end
        step(1);
        exp_v = exp_q.pop_front(); checks++;
        if ({31'b0, irq_v[0]} !== exp_v) begin errors++; $display("FAIL edge_wins_irq1 got %0b want %0d", irq_v[0], exp_v); end
    endtask

    task automatic test_ignored_writes;
        bus_write(2'd0, 32'hFFFF_FFFF);
        bus_write(2'd2, 32'hFFFF_FFFF);
        exp_q.push_back(32'h6);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h6);
        exp_q.push_back(32'h4);
        rd_at(2'd0); exp_v = exp_q.pop_front(); checks++;
        if (rd[0] !== exp_v) begin errors++; $display("FAIL ro_data got %h want %h", rd[0], exp_v); end
        rd_at(2'd2); exp_v = exp_q.pop_front(); checks++;
        if (rd[0] !== exp_v) begin errors++; $display("FAIL reserved got %h want %h", rd[0], exp_v); end
        rd_at(2'd1); exp_v = exp_q.pop_front(); checks++;
        if (rd[0] !== exp_v) begin errors++; $display("FAIL mask_kept got %h want %h", rd[0], exp_v); end
        rd_at(2'd3); exp_v = exp_q.pop_front(); checks++;
        if (rd[0] !== exp_v) begin errors++; $display("FAIL edge_kept got %h want %h", rd[0], exp_v); end
    endtask

    task automatic test_reset_mid;
        in_p[0] = 4'h0;
        step(3);
        #2;
        reset_n = 1'b0;
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        rd_at(2'd0); exp_v = exp_q.pop_front(); checks++;
        if (rd[0] !== exp_v) begin errors++; $display("FAIL async_data got %h want %h", rd[0], exp_v); end
        rd_at(2'd1); exp_v = exp_q.pop_front(); checks++;
        if (rd[0] !== exp_v) begin errors++; $display("FAIL async_mask got %h want %h", rd[0], exp_v); end
        rd_at(2'd3); exp_v = exp_q.pop_front(); checks++;
        if (rd[0] !== exp_v) begin errors++; $display("FAIL async_edge got %h want %h", rd[0], exp_v); end
        exp_v = exp_q.pop_front(); checks++;
        if ({31'b0, irq_v[0]} !== exp_v) begin errors++; $display("FAIL async_irq got %0b want %0d", irq_v[0], exp_v); end
        @(negedge clk);
        reset_n = 1'b1;
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        step(8);
        rd_at(2'd0); exp_v = exp_q.pop_front(); checks++;
        if (rd[0] !== exp_v) begin errors++; $display("FAIL post_reset_data got %h want %h", rd[0], exp_v); end
        rd_at(2'd3); exp_v = exp_q.pop_front(); checks++;
        if (rd[0] !== exp_v) begin errors++; $display("FAIL post_reset_edge got %h want %h", rd[0], exp_v); end
    endtask

    initial begin
        test_reset;
        test_glitch_and_debounce;
        test_irq;
        test_edge_types;
        test_edge_vs_clear;
        test_ignored_writes;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
